// File: rtl/align_job_ctrl.sv
// align_job_ctrl: per-job sequencer (score, traceback capture, reversed drain).
// Optional ALIGN_TB_TIMEOUT_EN adds SCORE and traceback watchdogs.
module align_job_ctrl #(
    parameter int B = 4,
    parameter int L = 8,
    parameter int TMO = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           job_valid,
    output logic           job_ready,
    input  logic [3*L-1:0] job_r,
    input  logic [3*L-1:0] job_q,
    output logic           sa_start,
    input  logic           sa_done,
    output logic [3*L-1:0] tb_r_sub,
    output logic [3*L-1:0] tb_q_sub,
    output logic           start_traceback,
    input  logic [2:0]     tb_out_r,
    input  logic [2:0]     tb_out_q,
    input  logic           tb_finish,
    output logic           aln_valid,
    input  logic           aln_ready,
    output logic [2:0]     aln_r,
    output logic [2:0]     aln_q,
    output logic           aln_last,
    output logic           err
);
    localparam int N = 2 * L;
    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;
    typedef enum logic [2:0] {IDLE, SCORE, TB_INIT, TB_RUN, DRAIN} state_t;
    state_t state, state_n;
    logic [CW-1:0] count;
    logic [5:0] mem [N];
    logic [AW-1:0] rd;
    logic accept, cap, pop, err_set;
`ifdef ALIGN_TB_TIMEOUT_EN
    localparam int TW = $clog2(4 * TMO);
    logic [TW-1:0] tcnt;
    // TB_INIT and TB_RUN share one run of the watchdog.
    always_ff @(posedge clk)
        if (rst) tcnt <= '0;
        else tcnt <= (state == state_n || state == TB_INIT) ? tcnt + 1'b1 : '0;
`endif
    assign job_ready = state == IDLE && B > 0 && TMO > 0;
    assign accept = state == IDLE && job_valid;
    assign start_traceback = state == TB_INIT || state == TB_RUN;
    assign rd = AW'(count - 1'b1);
    assign aln_valid = state == DRAIN && count != '0;
    assign aln_r = aln_valid ? mem[rd][5:3] : 3'd0;
    assign aln_q = aln_valid ? mem[rd][2:0] : 3'd0;
    assign aln_last = aln_valid && count == CW'(1);
    always_comb begin
        state_n = state;
        cap = 1'b0;
        pop = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: state_n = job_valid ? SCORE : IDLE;
            SCORE: begin
                if (sa_done && !sa_start) state_n = TB_INIT;
`ifdef ALIGN_TB_TIMEOUT_EN
                else if (tcnt == TW'(4 * TMO - 1)) begin
                    state_n = IDLE;
                    err_set = 1'b1;
                end
`endif
            end
            TB_INIT: state_n = TB_RUN;
            TB_RUN: begin
                cap = {tb_out_r, tb_out_q} != 6'h3f;
                if (tb_finish) state_n = DRAIN;
                else if (cap && count == CW'(N - 1)) begin
                    state_n = DRAIN;
                    err_set = 1'b1;
                end
`ifdef ALIGN_TB_TIMEOUT_EN
                else if (tcnt >= TW'(TMO - 1)) begin
                    state_n = DRAIN;
                    err_set = 1'b1;
                end
`endif
            end
            DRAIN: begin
                if (count == '0) begin
                    state_n = IDLE;
                    err_set = 1'b1;
                end else if (aln_ready) begin
                    pop = 1'b1;
                    if (count == CW'(1)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (cap) mem[count[AW-1:0]] <= {tb_out_r, tb_out_q};
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            err <= 1'b0;
            sa_start <= 1'b0;
            tb_r_sub <= '0;
            tb_q_sub <= '0;
        end else begin
            state <= state_n;
            sa_start <= accept;
            if (accept) begin
                tb_r_sub <= job_r;
                tb_q_sub <= job_q;
                count <= '0;
                err <= 1'b0;
            end
            if (err_set) err <= 1'b1;
            if (cap) count <= count + 1'b1;
            if (pop) count <= count - 1'b1;
        end
    end
endmodule

// File: doc/align_job_ctrl.md
Name: align_job_ctrl

Overview:
- Per-job sequencer for one sub-sequence alignment.
- Accepts an R/Q sub-sequence pair, starts the scoring array, then drives the traceback unit.
- Captures the traceback's end-to-start base pairs and streams them out in start-to-end order over a valid/ready interface.
- Sits between the host job interface and the scoring array / traceback pair.

Parameters:
- B, 4: number of PEs in the scoring array; passed through for consistency.
- L, 8: sub-sequence length in bases; each base is 3 bits.
- TMO, 24: traceback watchdog limit in cycles; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- job_valid  in  1  new job offered.
- job_ready  out  1  controller can accept a job.
- job_r  in  3L  R sub-sequence.
- job_q  in  3L  Q sub-sequence.
- sa_start  out  1  one-cycle start pulse to the scoring array.
- sa_done  in  1  scoring array finished; traceback memory is valid.
- tb_r_sub  out  3L  latched R sent to the traceback unit.
- tb_q_sub  out  3L  latched Q sent to the traceback unit.
- start_traceback  out  1  held high for the whole traceback run.
- tb_out_r  in  3  traceback reference base.
- tb_out_q  in  3  traceback query base.
- tb_finish  in  1  traceback complete.
- aln_valid  out  1  output pair valid.
- aln_ready  in  1  downstream accepts the pair.
- aln_r  out  3  aligned reference base (4 = gap).
- aln_q  out  3  aligned query base (4 = gap).
- aln_last  out  1  marks the final pair of a job.
- err  out  1  sticky job error; cleared when the next job is accepted.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, job_ready=1, sa_start=0, start_traceback=0, aln_valid=0, aln_last=0, aln_r=aln_q=0, err=0, tb_r_sub=tb_q_sub=0, buffer count=0.
- Reset asserted mid-operation returns to IDLE on the next edge. start_traceback drops on that same edge; partial buffer contents are discarded.
- Buffer: 2L entries of {r,q} (6 bits each). Write pointer/count width is clog2(2L)+1.
- IDLE:
  - job_ready=1.
  - On job_valid & job_ready: latch job_r/job_q into tb_r_sub/tb_q_sub, clear err and count, go SCORE.
  - sa_start pulses high for exactly the first SCORE cycle.
- SCORE:
  - job_ready=0.
  - Wait for sa_done; ignore sa_done in the cycle sa_start is high.
  - On sa_done go TB_INIT and raise start_traceback.
- TB_INIT:
  - Exactly one cycle. The traceback unit loads its initial state here.
  - Outputs in this cycle are 3'b111/3'b111; capture nothing. Go TB_RUN.
- TB_RUN:
  - start_traceback=1.
  - Each cycle where {tb_out_r,tb_out_q} != {3'b111,3'b111}, write the pair at buffer[count] and increment count.
  - When tb_finish=1, capture that cycle's pair under the same rule, then drop start_traceback next edge and go DRAIN.
  - If count reaches 2L without tb_finish: set err, drop start_traceback, go DRAIN with the pairs already captured.
- DRAIN:
  - Present buffer[count-1] first and walk down to buffer[0]. This reverses the traceback order into alignment order.
  - aln_valid=1 while entries remain. A pointer advances only on aln_valid & aln_ready.
  - aln_r/aln_q/aln_last must hold stable while aln_valid=1 and aln_ready=0.
  - aln_last=1 on buffer[0].
  - After the last handshake, return to IDLE; job_ready rises on the following cycle.
  - count=0 at DRAIN entry: go IDLE directly with err=1 and no output beat.
- Back-pressure: aln_ready low for any number of cycles stalls only DRAIN, with no loss.
- job_valid outside IDLE is ignored; job_ready=0.
- Latency: first aln_valid appears 1 cycle after the TB_RUN→DRAIN transition.

Optional Feature:
- Macro: ALIGN_TB_TIMEOUT_EN.
- When defined: a cycle counter runs from TB_INIT entry. If tb_finish is not seen within TMO cycles, set err, drop start_traceback and go DRAIN with the current buffer.
- A second counter in SCORE aborts to IDLE with err=1 after 4·TMO cycles without sa_done.
- When undefined: no counters are instantiated and the controller waits indefinitely. Buffer-full abort still applies.

Test Plan:
- Reset mid-TB_RUN (L=8): assert rst for 1 cycle with start_traceback high -> next cycle start_traceback=0, job_ready=1, aln_valid=0, err=0.
- Clean job: 8 diagonal pairs (r=1..7,0 / q=same) with tb_finish on the 8th -> 8 beats out in reverse capture order; aln_last on the 8th; err=0.
- Gaps: 10 captured pairs including r=4 gaps, aln_ready toggling 1,0,0,1 -> 10 beats, stable data during stalls, aln_last only on the 10th.
- No finish: 16 pairs, none with tb_finish -> 16 beats out, err=1 after the 16th capture, start_traceback low within 1 cycle.
- TB_INIT filter: 3'b111/3'b111 presented in TB_INIT and once in TB_RUN -> neither is captured; count is unaffected.
- With ALIGN_TB_TIMEOUT_EN, TMO=24: tb_finish never asserted, 3 pairs captured -> abort at cycle 24, 3 beats out, err=1; without the macro, start_traceback stays high.
